// File: rtl/modp_addsub_serial_pkg.sv
// rtl/modp_addsub_serial_pkg.sv - shared widths, modulus and FSM encoding for the serial GF(p) add/sub unit
package modp_addsub_serial_pkg;

  localparam int R_BITS = 112;
  localparam logic [R_BITS-1:0] MODULUS = 112'hDB7C2ABF62E35E668076BEAD208B;
  localparam int DIGIT_W = 16;

  typedef enum logic [1:0] {
    ST_LOAD = 2'd0,
    ST_RUN  = 2'd1,
    ST_SEL  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/modp_addsub_serial_if.sv
// rtl/modp_addsub_serial_if.sv - operand/result bundle between the operand-load stage and the add/sub unit
interface modp_addsub_serial_if #(
  parameter int R_BITS = modp_addsub_serial_pkg::R_BITS
);

  logic [R_BITS-1:0] a;
  logic [R_BITS-1:0] b;
  logic              op_add;
  logic [R_BITS-1:0] r;
  logic              done;
  logic              busy;

  modport master (output a, output b, output op_add, input r, input done, input busy);
  modport slave  (input a, input b, input op_add, output r, output done, output busy);

endinterface

// File: rtl/modp_addsub_serial_digit_addsub.sv
// rtl/modp_addsub_serial_digit_addsub.sv - combinational W-bit adder/subtractor with carry/borrow in and out
module digit_addsub #(
  parameter int W = 16
) (
  input  logic [W-1:0] x_i,
  input  logic [W-1:0] y_i,
  input  logic         cin_i,
  input  logic         sub_i,
  output logic [W-1:0] d_o,
  output logic         cout_o
);

  logic [W:0] res;

  // The extra MSB is the carry on add and the borrow on subtract.
  always_comb begin
    if (sub_i) begin
      res = {1'b0, x_i} - {1'b0, y_i} - {{W{1'b0}}, cin_i};
    end else begin
      res = {1'b0, x_i} + {1'b0, y_i} + {{W{1'b0}}, cin_i};
    end
  end

  assign d_o    = res[W-1:0];
  assign cout_o = res[W];

endmodule

// File: rtl/modp_addsub_serial.sv
// rtl/modp_addsub_serial.sv - digit-serial (a +/- b) mod p; one operation per AU_sub_rst release, fixed N+2 latency
module modp_addsub_serial #(
  parameter int                R_BITS  = modp_addsub_serial_pkg::R_BITS,
  parameter logic [R_BITS-1:0] MODULUS = modp_addsub_serial_pkg::MODULUS,
  parameter int                DIGIT_W = modp_addsub_serial_pkg::DIGIT_W
) (
  input  logic                 clk,
  input  logic                 AU_sub_rst,
  modp_addsub_serial_if.slave  au
);

  import modp_addsub_serial_pkg::*;

  localparam int N   = R_BITS / DIGIT_W;
  localparam int K_W = (N > 1) ? $clog2(N) : 1;

  state_t             state_q, state_d;
  logic [K_W-1:0]     k_q, k_d;
  logic [R_BITS-1:0]  a_q, a_d;
  logic [R_BITS-1:0]  b_q, b_d;
  logic [R_BITS-1:0]  p_q, p_d;
  logic [R_BITS-1:0]  prim_q, prim_d;
  logic [R_BITS-1:0]  corr_q, corr_d;
  logic               c1_q, c1_d;
  logic               c2_q, c2_d;
  logic               op_q, op_d;
  logic [R_BITS-1:0]  r_q, r_d;
  logic               done_q, done_d;
  logic               busy_q, busy_d;

  logic [DIGIT_W-1:0] s_k, t_k;
  logic               c1_out, c2_out;

  digit_addsub #(.W(DIGIT_W)) u_chain1 (
    .x_i    (a_q[DIGIT_W-1:0]),
    .y_i    (b_q[DIGIT_W-1:0]),
    .cin_i  (c1_q),
    .sub_i  (~op_q),
    .d_o    (s_k),
    .cout_o (c1_out)
  );

  // Correction runs the opposite direction: add p back after a subtract, take p off after an add.
  digit_addsub #(.W(DIGIT_W)) u_chain2 (
    .x_i    (s_k),
    .y_i    (p_q[DIGIT_W-1:0]),
    .cin_i  (c2_q),
    .sub_i  (op_q),
    .d_o    (t_k),
    .cout_o (c2_out)
  );

  always_ff @(posedge clk or posedge AU_sub_rst) begin
    if (AU_sub_rst) begin
      state_q <= ST_LOAD;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    a_d     = a_q;
    b_d     = b_q;
    p_d     = p_q;
    prim_d  = prim_q;
    corr_d  = corr_q;
    c1_d    = c1_q;
    c2_d    = c2_q;
    op_d    = op_q;
    r_d     = r_q;
    done_d  = done_q;
    busy_d  = busy_q;
    case (state_q)
      ST_LOAD: begin
        a_d     = au.a;
        b_d     = au.b;
        p_d     = MODULUS;
        op_d    = au.op_add;
        c1_d    = 1'b0;
        c2_d    = 1'b0;
        k_d     = '0;
        busy_d  = 1'b1;
        state_d = ST_RUN;
      end
      ST_RUN: begin
        a_d    = a_q >> DIGIT_W;
        b_d    = b_q >> DIGIT_W;
        p_d    = p_q >> DIGIT_W;
        prim_d = {s_k, prim_q[R_BITS-1:DIGIT_W]};
        corr_d = {t_k, corr_q[R_BITS-1:DIGIT_W]};
        c1_d   = c1_out;
        c2_d   = c2_out;
        if (k_q == K_W'(N - 1)) begin
          k_d     = '0;
          state_d = ST_SEL;
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      ST_SEL: begin
        // Add: a final carry or no final borrow from a+b-p both mean the sum reached p.
        if (op_q) begin
          r_d = (c1_q || !c2_q) ? corr_q : prim_q;
        end else begin
          r_d = c1_q ? corr_q : prim_q;
        end
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_DONE;
      end
      default: begin
        state_d = ST_LOAD;
      end
    endcase
  end

  always_ff @(posedge clk or posedge AU_sub_rst) begin
    if (AU_sub_rst) begin
      k_q    <= '0;
      a_q    <= '0;
      b_q    <= '0;
      p_q    <= '0;
      prim_q <= '0;
      corr_q <= '0;
      c1_q   <= 1'b0;
      c2_q   <= 1'b0;
      op_q   <= 1'b0;
      r_q    <= '0;
      done_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      k_q    <= k_d;
      a_q    <= a_d;
      b_q    <= b_d;
      p_q    <= p_d;
      prim_q <= prim_d;
      corr_q <= corr_d;
      c1_q   <= c1_d;
      c2_q   <= c2_d;
      op_q   <= op_d;
      r_q    <= r_d;
      done_q <= done_d;
      busy_q <= busy_d;
    end
  end

  assign au.r    = r_q;
  assign au.done = done_q;
  assign au.busy = busy_q;

endmodule

// File: tb/tb_modp_addsub_serial.sv
// tb/tb_modp_addsub_serial.sv - vector table, corner sequences and random ops against an arithmetic (a +/- b) mod p model
module tb_modp_addsub_serial;

  localparam int RB = 112;
  localparam logic [RB-1:0] P = 112'hDB7C2ABF62E35E668076BEAD208B;
  localparam int LAT = 9;
  localparam int NRAND = 3000;

  typedef struct {
    logic [RB-1:0] a;
    logic [RB-1:0] b;
    logic          op;
    logic [RB-1:0] exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  modp_addsub_serial_if #(.R_BITS(RB)) au ();

  modp_addsub_serial dut (
    .clk        (clk),
    .AU_sub_rst (rst),
    .au         (au)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", nm, act, exp);
    end
  endtask

  function automatic logic [RB-1:0] ref_op(input logic [RB-1:0] x, input logic [RB-1:0] y, input logic add);
    logic [RB:0] s;
    if (add) begin
      s = {1'b0, x} + {1'b0, y};
      if (s >= {1'b0, P}) s = s - {1'b0, P};
    end else begin
      if (x >= y) s = {1'b0, x} - {1'b0, y};
      else        s = {1'b0, x} + {1'b0, P} - {1'b0, y};
    end
    return s[RB-1:0];
  endfunction

  function automatic logic [RB-1:0] rand_red();
    logic [127:0] w;
    w = {$urandom, $urandom, $urandom, $urandom};
    w = w % {16'd0, P};
    return w[RB-1:0];
  endfunction

  // Releases reset with the given operands; optionally scrambles the inputs after the load edge.
  task automatic run_op(input logic [RB-1:0] ai, input logic [RB-1:0] bi, input logic opi,
                        input bit scramble, output logic [RB-1:0] res, output int lat,
                        output logic busy_run);
    @(negedge clk);
    rst = 1'b1;
    au.a = ai;
    au.b = bi;
    au.op_add = opi;
    @(negedge clk);
    rst = 1'b0;
    lat = 0;
    busy_run = 1'b0;
    while (lat < 20 && au.done !== 1'b1) begin
      @(posedge clk);
      #1;
      lat++;
      if (lat == 1) busy_run = au.busy;
      if (scramble) begin
        au.a = rand_red();
        au.b = rand_red();
        au.op_add = $urandom_range(0, 1);
      end
    end
    res = au.r;
  endtask

  vec_t          vecs[8];
  logic [RB-1:0] res;
  logic [RB-1:0] held;
  logic [RB-1:0] ra, rb_;
  logic          rop;
  logic          brun;
  int            lat;
  int            bad_r;
  int            bad_lat;

  initial begin
    au.a = '0;
    au.b = '0;
    au.op_add = 1'b0;
    vecs[0] = '{a: 112'd5,     b: 112'd3,     op: 1'b0, exp: 112'd2};
    vecs[1] = '{a: 112'd0,     b: 112'd1,     op: 1'b0, exp: 112'hDB7C2ABF62E35E668076BEAD208A};
    vecs[2] = '{a: 112'h1234,  b: 112'h1234,  op: 1'b0, exp: 112'd0};
    vecs[3] = '{a: P - 112'd1, b: 112'd1,     op: 1'b1, exp: 112'd0};
    vecs[4] = '{a: P - 112'd1, b: P - 112'd1, op: 1'b1, exp: 112'hDB7C2ABF62E35E668076BEAD2089};
    vecs[5] = '{a: 112'd1,     b: 112'd2,     op: 1'b1, exp: 112'd3};
    vecs[6] = '{a: 112'd3,     b: 112'd5,     op: 1'b0, exp: 112'hDB7C2ABF62E35E668076BEAD2089};
    vecs[7] = '{a: P - 112'd1, b: 112'd0,     op: 1'b0, exp: 112'hDB7C2ABF62E35E668076BEAD208A};

    #1;
    chk("reset_r", au.r, '0);
    chk("reset_done", au.done, 1'b0);
    chk("reset_busy", au.busy, 1'b0);

    for (int i = 0; i < 8; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].op, 1'b0, res, lat, brun);
      chk($sformatf("vec%0d_r", i), res, vecs[i].exp);
      chk($sformatf("vec%0d_lat", i), lat, LAT);
      chk($sformatf("vec%0d_busy_run", i), brun, 1'b1);
      chk($sformatf("vec%0d_busy_done", i), au.busy, 1'b0);
    end

    // Result held in DONE while inputs wander.
    held = au.r;
    repeat (3) begin
      @(negedge clk);
      au.a = rand_red();
      au.b = rand_red();
      au.op_add = ~au.op_add;
    end
    #1;
    chk("hold_r", au.r, held);
    chk("hold_done", au.done, 1'b1);

    // Inputs change every cycle after load: result reflects the latched pair only.
    run_op(112'hABCDEF0123456789, 112'hFFFFFFFFFFFFFFFFFFFF, 1'b0, 1'b1, res, lat, brun);
    chk("scramble_r", res, ref_op(112'hABCDEF0123456789, 112'hFFFFFFFFFFFFFFFFFFFF, 1'b0));
    chk("scramble_lat", lat, LAT);

    // Reset between clock edges clears r and done without waiting for an edge.
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("async_clr_r", au.r, '0);
    chk("async_clr_done", au.done, 1'b0);

    // Abort during RUN with k=3, then a fresh operation completes normally.
    @(negedge clk);
    au.a = 112'd100;
    au.b = 112'd7;
    au.op_add = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    chk("abort_busy_before", au.busy, 1'b1);
    rst = 1'b1;
    #1;
    chk("abort_r", au.r, '0);
    chk("abort_done", au.done, 1'b0);
    chk("abort_busy", au.busy, 1'b0);
    run_op(112'd7, 112'd100, 1'b0, 1'b0, res, lat, brun);
    chk("after_abort_r", res, P - 112'd93);
    chk("after_abort_lat", lat, LAT);

    bad_r = 0;
    bad_lat = 0;
    for (int i = 0; i < NRAND; i++) begin
      ra  = rand_red();
      rb_ = rand_red();
      rop = $urandom_range(0, 1);
      if (i % 10 == 0) ra = P - 112'd1 - ra[15:0];
      run_op(ra, rb_, rop, 1'b0, res, lat, brun);
      checks++;
      if (res !== ref_op(ra, rb_, rop)) begin
        errors++;
        bad_r++;
        if (bad_r <= 5)
          $display("FAIL rand_r op=%0d a=%h b=%h: got %h required %h", rop, ra, rb_, res, ref_op(ra, rb_, rop));
      end
      checks++;
      if (lat != LAT) begin
        errors++;
        bad_lat++;
        if (bad_lat <= 5) $display("FAIL rand_lat: got %0d required %0d", lat, LAT);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
